// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parameterised synchronous FIFO.
package fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    // The occupancy counter needs one extra bit so it can represent DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Handshake, data and status bundle for param_sync_fifo.
// The overflow/underflow signals exist only when FIFO_ERR_EN is defined.
interface param_sync_fifo_if #(
    parameter int DATA_W = fifo_pkg::DATA_W_DEF,
    parameter int DEPTH  = fifo_pkg::DEPTH_DEF
);
    localparam int CNT_W = fifo_pkg::cnt_width(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
`ifdef FIFO_ERR_EN
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, din, rd_en,
        input  dout, dout_valid, full, empty, almost_full, almost_empty, count,
        input  overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, dout_valid, full, empty, almost_full, almost_empty, count,
        output overflow, underflow
    );
`else
    modport master (
        output wr_en, din, rd_en,
        input  dout, dout_valid, full, empty, almost_full, almost_empty, count
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, dout_valid, full, empty, almost_full, almost_empty, count
    );
`endif

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one combinational read port.
// Contents are deliberately never reset.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The top registers this into dout, giving one cycle of read latency.
    assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO: pointer/count control, registered read data and status flags.
// Define FIFO_ERR_EN to add sticky overflow/underflow flags.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic               clk,
    input  logic               rst,
    param_sync_fifo_if.slave   bus
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              full;
    logic              empty;
    logic              wr_acc;
    logic              rd_acc;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);

    // Full + read lets the read through and drops the write; empty + write
    // stores the write with no fall-through to dout.
    assign wr_acc = bus.wr_en && !full;
    assign rd_acc = bus.rd_en && !empty;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (bus.din),
        .raddr (rptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= rptr + 1'b1;
                dout <= rdata;
            end
            dout_valid <= rd_acc;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.dout         = dout;
    assign bus.dout_valid   = dout_valid;
    assign bus.count        = count;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count >= CNT_W'(AF_THRESH));
    assign bus.almost_empty = (count <= CNT_W'(AE_THRESH));

`ifdef FIFO_ERR_EN
    logic overflow;
    logic underflow;

    // Sticky until reset so software can spot a lost word after the fact.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (bus.wr_en && full) begin
                overflow <= 1'b1;
            end
            if (bus.rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;
`endif

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL expose parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 SHALL expose parameter DEPTH, default 16, number of storage entries (power of 2, >=2).
REQ-003 SHALL expose parameter AF_THRESH, default DEPTH-1, almost_full assert level (1..DEPTH-1).
REQ-004 SHALL expose parameter AE_THRESH, default 1, almost_empty assert level (1..DEPTH-1).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port wr_en  input  1  write request.
REQ-008 SHALL have port din  input  DATA_W  write data.
REQ-009 SHALL have port rd_en  input  1  read request.
REQ-010 SHALL have port dout  output  DATA_W  registered read data.
REQ-011 SHALL have port dout_valid  output  1  one-cycle pulse, dout updated this cycle.
REQ-012 SHALL have port full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 SHALL have ports overflow, underflow  output  1 each  sticky error flags (present only with FIFO_ERR_EN).

Function
REQ-015 Write SHALL be accepted when wr_en && !full; din is stored at wptr, and wptr advances by 1.
REQ-016 Read SHALL be accepted when rd_en && !empty; mem[rptr] is registered to dout, and rptr advances by 1.
REQ-017 dout SHALL update on the edge that accepts the read (1-cycle latency from rd_en); dout_valid SHALL be 1 for that cycle only.
REQ-018 dout SHALL hold its value when no read is accepted.
REQ-019 Simultaneous accepted read and write SHALL both occur in one cycle, leaving count unchanged.
REQ-020 When full, wr_en && rd_en: the read is accepted, the write is rejected, and count decrements.
REQ-021 When empty, wr_en && rd_en: the write is accepted, the read is rejected (no fall-through), dout_valid=0, and count=1.
REQ-022 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 by natural overflow.
REQ-023 count SHALL be +1 on write-only, -1 on read-only, and unchanged otherwise; it SHALL never exceed DEPTH or underflow below 0.
REQ-024 The flags SHALL be combinational from count: empty=(count==0), full=(count==DEPTH), almost_full=(count>=AF_THRESH), almost_empty=(count<=AE_THRESH).
REQ-025 Rejected requests SHALL change no state (apart from the error flags in REQ-030).

Reset
REQ-026 On rst=1 at a rising edge: wptr=0, rptr=0, count=0, dout=0, and dout_valid=0, giving empty=1, almost_empty=1, full=0, and almost_full=0.
REQ-027 rst SHALL take priority over wr_en/rd_en in the same cycle, and mid-operation reset SHALL discard all contents.
REQ-028 Memory array contents SHALL NOT be reset.
REQ-029 The overflow and underflow flags SHALL clear to 0 on reset.

Configuration
REQ-030 With macro FIFO_ERR_EN defined, overflow SHALL set on wr_en && full with the write rejected, underflow SHALL set on rd_en && empty, and both SHALL remain set until rst.
REQ-031 Without FIFO_ERR_EN, the overflow/underflow ports and logic SHALL be absent, and all other behaviour is identical.

Structure
REQ-032 Package fifo_pkg SHALL hold the default constants (DATA_W_DEF=8, DEPTH_DEF=16) and the function for occupancy width.
REQ-033 Storage SHALL be in sub-module fifo_mem: a DEPTH x DATA_W array with one synchronous write port and one read port, instantiated once.
REQ-034 Pointer/count control and flags SHALL reside in param_sync_fifo.

Verification
REQ-035 Default params: reset, then write 0x01..0x10 (16 writes) -> full=1, almost_full asserted at count=15, 17th write ignored; 16 reads return 0x01..0x10 in order, each one cycle after its rd_en, then empty=1.
REQ-036 Wrap: write 10, read 10, write 12, read 12 with data 0xA0+i -> data in order across the pointer wrap, count returns to 0.
REQ-037 Simultaneous wr_en/rd_en at count=5 for 8 cycles -> count stays 5, and reads return the oldest data in order; at full: the write is dropped and count=15; at empty: the write is accepted, dout_valid=0, and count=1.
REQ-038 Reset mid-stream at count=7 with wr_en=1 -> next cycle count=0, empty=1, dout=0, and the following read request is rejected.
REQ-039 FIFO_ERR_EN defined: read when empty -> underflow=1 and held; fill and write once more -> overflow=1; rst -> both cleared.
REQ-040 DATA_W=32, DEPTH=4, AF_THRESH=3, AE_THRESH=2: almost_empty=1 for count<=2, almost_full=1 for count>=3, full at 4, and 32-bit data integrity holds.
